// File: rtl/fpu_addsub_issue.sv
// Issue/bypass front end for a single-precision add/sub core: special operands
// are resolved locally, everything else is handed to the core and its result captured.
module fpu_addsub_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_opc,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        core_opc,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_flags,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t      state_q, state_d;
  logic        core_opc_q, core_opc_d;
  logic [31:0] core_a_q, core_a_d;
  logic [31:0] core_b_q, core_b_d;
  logic [31:0] res_data_q, res_data_d;
  logic [3:0]  res_flags_q, res_flags_d;
  logic [15:0] ops_done_q, ops_done_d;

  logic        sa, sb;
  logic        a_nan, a_inf, a_zero;
  logic        b_nan, b_inf, b_zero;
  logic        byp;
  logic [31:0] byp_data;
  logic [3:0]  byp_flags;

  assign sa     = in_a[31];
  assign sb     = in_b[31] ^ in_opc;
  assign a_nan  = (&in_a[30:23]) & (|in_a[22:0]);
  assign a_inf  = (&in_a[30:23]) & ~(|in_a[22:0]);
  assign a_zero = ~(|in_a[30:23]);
  assign b_nan  = (&in_b[30:23]) & (|in_b[22:0]);
  assign b_inf  = (&in_b[30:23]) & ~(|in_b[22:0]);
  assign b_zero = ~(|in_b[30:23]);

  // Flags: [3] bypass, [2] zero, [1] infinite, [0] invalid.
  always_comb begin
    byp       = 1'b1;
    byp_data  = '0;
    byp_flags = '0;
    if (a_nan || b_nan) begin
      byp_data  = QNAN;
      byp_flags = 4'b1001;
    end else if (a_inf && b_inf && (sa != sb)) begin
      byp_data  = QNAN;
      byp_flags = 4'b1001;
    end else if (a_inf) begin
      byp_data  = {sa, 8'hFF, 23'h0};
      byp_flags = 4'b1010;
    end else if (b_inf) begin
      byp_data  = {sb, 8'hFF, 23'h0};
      byp_flags = 4'b1010;
    end else if (a_zero && b_zero) begin
      byp_data  = {sa & sb, 31'h0};
      byp_flags = 4'b1100;
    end else if (a_zero) begin
      byp_data  = {sb, in_b[30:0]};
      byp_flags = 4'b1000;
    end else if (b_zero) begin
      byp_data  = {sa, in_a[30:0]};
      byp_flags = 4'b1000;
    end else if ((in_a[30:0] == in_b[30:0]) && (sa != sb)) begin
      // Exact cancellation is outside what the core can produce.
      byp_data  = '0;
      byp_flags = 4'b1100;
    end else begin
      byp = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    core_opc_d  = core_opc_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    ops_done_d  = ops_done_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          core_opc_d = in_opc;
          core_a_d   = in_a;
          core_b_d   = in_b;
          if (byp) begin
            res_data_d  = byp_data;
            res_flags_d = byp_flags;
            state_d     = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        res_data_d  = core_out;
        res_flags_d = '0;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      core_opc_q  <= 1'b0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      core_opc_q  <= core_opc_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign res_valid = (state_q == DONE);
  assign core_opc  = core_opc_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign ops_done  = ops_done_q;

endmodule

// File: doc/fpu_addsub_issue.md
FPU_ADDSUB_ISSUE -- requirements
Module: fpu_addsub_issue

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 SHALL have port in_opc, input, 1 bit: operation select, 0 = A+B, 1 = A-B.
REQ-007 SHALL have ports in_a and in_b, input, 32 bits each: IEEE-754 single-precision operands.
REQ-008 SHALL have port core_opc, output, 1 bit: registered opcode driven to the downstream add/sub core.
REQ-009 SHALL have ports core_a and core_b, output, 32 bits each: registered operands driven to the core.
REQ-010 SHALL have port core_out, input, 32 bits: result of the core, registered by the core on the clk edge after it samples core_*.
REQ-011 SHALL have port res_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port res_data, output, 32 bits: the final result.
REQ-014 SHALL have port res_flags, output, 4 bits: [0] invalid, [1] infinite, [2] zero, [3] bypass (core not used).
REQ-015 SHALL have port ops_done, output, 16 bits: count of completed results.

Function
REQ-016 SHALL implement an FSM with states IDLE, EXEC, CAPT and DONE; in_ready = (state==IDLE) && !rst.
REQ-017 SHALL, in IDLE on in_valid && in_ready, latch in_a, in_b and in_opc into core_a, core_b and core_opc, and classify the operands in the same cycle.
REQ-018 SHALL define the effective B sign as sb = in_b[31] ^ in_opc; an operand is NaN when exp==255 && mant!=0, Inf when exp==255 && mant==0, and Zero when exp==0 (denormals flush to zero).
REQ-019 SHALL apply the following bypass rules in priority order: any NaN -> 0x7FC00000 with invalid set; Inf with Inf of opposite effective sign -> 0x7FC00000 with invalid set; any other Inf -> that Inf carrying its effective sign, with infinite set; both Zero -> 0x80000000 if both effective signs are negative, else 0x00000000, with zero set; one Zero -> the other operand carrying its effective sign.
REQ-020 SHALL bypass equal magnitudes (in_a[30:0]==in_b[30:0]) with opposite effective signs, since the core cannot produce an exact-cancellation result -> 0x00000000 with zero set.
REQ-021 SHALL, on a bypass, load res_data and res_flags (bypass bit set) and go IDLE -> DONE; res_valid then rises 1 cycle after the accept edge.
REQ-022 SHALL, on a non-bypass, go IDLE -> EXEC -> CAPT; on the CAPT edge it loads res_data from core_out and sets res_flags = 0, then goes to DONE; res_valid rises 3 edges after the accept edge.
REQ-023 SHALL hold core_* stable from accept until the next accept.
REQ-024 SHALL assert res_valid only in DONE and hold res_data and res_flags stable while res_valid && !res_ready.
REQ-025 SHALL, in DONE on res_ready, go to IDLE, deassert res_valid, and increment ops_done modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-026 SHALL NOT accept an input in the same cycle a result is retired; in_valid during EXEC/CAPT/DONE is ignored, not lost, because in_ready is 0.
REQ-027 SHALL leave res_data and res_flags unchanged in IDLE.

Reset
REQ-028 SHALL, while rst is high and regardless of clk, drive state=IDLE, in_ready=0, res_valid=0, res_data=0, res_flags=0, core_a=0, core_b=0, core_opc=0 and ops_done=0.
REQ-029 SHALL, when rst is asserted mid-operation (EXEC/CAPT/DONE), abandon the operation: no result is presented, ops_done is not incremented, and any later core_out is ignored.
REQ-030 SHALL raise in_ready in the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover: opc=0, A=0x3F800000, B=0x40000000 -> res_valid 3 edges after accept, res_data=0x40400000, res_flags=4'b0000, ops_done=1 after the handshake.
REQ-032 SHALL cover: opc=1, A=B=0x40400000 -> res_valid 1 edge after accept, res_data=0x00000000, res_flags=4'b1100.
REQ-033 SHALL cover: opc=1, A=B=0x7F800000 -> res_data=0x7FC00000, res_flags=4'b1001; and opc=0, A=0x7F800000, B=0x3F800000 -> 0x7F800000, res_flags=4'b1010.
REQ-034 SHALL cover: opc=1, A=0x00000000, B=0x40000000 -> res_data=0xC0000000, res_flags=4'b1000.
REQ-035 SHALL cover: res_ready=0 for 5 cycles with the next in_valid held high -> in_ready=0 and res_data stable throughout; the second operation is accepted on the cycle after the retiring handshake.
REQ-036 SHALL cover: rst pulsed during EXEC -> res_valid=0 immediately and no result before a new accept; separately, 65536 completions -> ops_done=0x0000.
